// File: rtl/led_frame_if.sv
// led_frame_if
// Groups the frame-write handshake, playback controls and display outputs of
// led_frame_scheduler.
//   master : frame source / sequencer controller (drives writes and controls)
//   slave  : led_frame_scheduler
// Signals:
//   wr_valid/wr_ready/wr_data/wr_hold : frame write handshake (36-bit image, 8-bit hold in ticks)
//   start/stop/clear/loop_en          : playback controls
//   busy/frame_idx/done/img           : playback status and registered image
// DEPTH must match the scheduler's DEPTH so frame_idx has the right width.
interface led_frame_if #(
    parameter int DEPTH = 4
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          wr_valid;
    logic          wr_ready;
    logic [35:0]   wr_data;
    logic [7:0]    wr_hold;
    logic          start;
    logic          stop;
    logic          clear;
    logic          loop_en;
    logic          busy;
    logic [IW-1:0] frame_idx;
    logic          done;
    logic [35:0]   img;

    modport master (
        output wr_valid, wr_data, wr_hold, start, stop, clear, loop_en,
        input  wr_ready, busy, frame_idx, done, img
    );

    modport slave (
        input  wr_valid, wr_data, wr_hold, start, stop, clear, loop_en,
        output wr_ready, busy, frame_idx, done, img
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
// Stores up to DEPTH frames (36-bit 6x6 image + 8-bit hold time in ticks) and
// plays them back in order on the img output, each for its hold time.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : led_frame_if slave (write handshake, start/stop/clear/loop_en,
//           busy/frame_idx/done/img)
//
// state | meaning
// IDLE  | frames may be written or cleared; img holds last shown frame
// PLAY  | frames shown in sequence, store is read-only
module led_frame_scheduler #(
    parameter int CLK_HZ  = 12_000_000,
    parameter int TICK_HZ = 1000,
    parameter int DEPTH   = 4
) (
    input logic        clk,
    input logic        rst_n,
    led_frame_if.slave bus
);
    localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [35:0]   img_q, img_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    hold_q, hold_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;

    logic [35:0]   mem_data [DEPTH];
    logic [7:0]    mem_hold [DEPTH];

    logic          wr_ready;
    logic          wr_fire;
    logic          tick;
    logic          is_last;
    logic [IW-1:0] next_idx;

    // A stored hold of 0 would never expire; it is shown for one tick instead.
    function automatic logic [7:0] hold_of(input logic [7:0] h);
        return (h == 8'd0) ? 8'd1 : h;
    endfunction

    assign wr_ready = (state_q == IDLE) && (count_q < COUNT_FULL);
    // clear discards a same-cycle write, including the store update.
    assign wr_fire  = bus.wr_valid && wr_ready && !bus.clear;
    assign tick     = (presc_q == PRESC_LAST);
    assign is_last  = (CW'(idx_q) == count_q - CW'(1));
    assign next_idx = is_last ? '0 : idx_q + IW'(1);

    // Store has no reset: after reset count=0 makes old entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_data[count_q[IW-1:0]] <= bus.wr_data;
            mem_hold[count_q[IW-1:0]] <= bus.wr_hold;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        img_d   = img_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    count_d = '0;
                    img_d   = '0;
                end else begin
                    if (wr_fire) begin
                        count_d = count_q + CW'(1);
                    end
                    if (bus.start && !bus.stop && (count_q != '0)) begin
                        state_d = PLAY;
                        idx_d   = '0;
                        img_d   = mem_data[0];
                        hold_d  = hold_of(mem_hold[0]);
                        presc_d = '0;
                    end
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    if (hold_q == 8'd1) begin
                        if (is_last && !bus.loop_en) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            // next_idx already wraps to 0 after the last frame
                            idx_d  = next_idx;
                            img_d  = mem_data[next_idx];
                            hold_d = hold_of(mem_hold[next_idx]);
                        end
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            img_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            img_q   <= img_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.busy      = (state_q == PLAY);
    assign bus.frame_idx = idx_q;
    assign bus.done      = done_q;
    assign bus.img       = img_q;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler
// Self-checking bench for led_frame_scheduler with CLK_HZ=1000, TICK_HZ=100
// (one tick every 10 cycles) and DEPTH=4. Inputs change 1 ns after a rising
// edge; outputs are checked at that same point, after the edge has settled.
module tb_led_frame_scheduler;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DEPTH   = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    localparam logic [35:0] FA = 36'h000000021;
    localparam logic [35:0] FB = 36'h00000C000;
    localparam logic [35:0] FC = 36'h0F0F0F0F0;
    localparam logic [35:0] FD = 36'h800000001;
    localparam logic [35:0] FE = 36'hFFFFFFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    led_frame_if #(.DEPTH(DEPTH)) bus ();

    led_frame_scheduler #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [35:0] data;
        logic [7:0]  hold;
        logic        start;
        logic        stop;
        logic        clear;
        logic        e_ready;
        logic        e_busy;
        logic [35:0] e_img;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    // reference model state for the randomized trials
    logic [35:0] r_data [DEPTH];
    int          r_hold [DEPTH];
    int          r_n;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [35:0] e_img, input logic e_busy,
                           input logic e_done, input logic [1:0] e_idx);
        chk({tag, "_img"},  64'(bus.img),       64'(e_img));
        chk({tag, "_busy"}, 64'(bus.busy),      64'(e_busy));
        chk({tag, "_done"}, 64'(bus.done),      64'(e_done));
        chk({tag, "_idx"},  64'(bus.frame_idx), 64'(e_idx));
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_hold  = '0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic write_frame(input logic [35:0] d, input logic [7:0] h);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_hold  = h;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    // Frame shown k cycles after playback entry: one tick per DIV cycles,
    // frame f lasts r_hold[f] ticks; a looping sequence repeats every total ticks.
    function automatic int frame_at(input int k, input bit loop);
        int t;
        int acc;
        int total;
        total = 0;
        for (int f = 0; f < r_n; f++) total += r_hold[f];
        t = k / DIV;
        if (loop) t = t % total;
        acc = 0;
        for (int f = 0; f < r_n; f++) begin
            acc += r_hold[f];
            if (t < acc) return f;
        end
        return r_n - 1;
    endfunction

    initial begin
        int n, tsum, big_t, stop_at, horizon, ks, fr, hv;
        bit loop, stopped;
        logic [63:0] rnd;
        logic [35:0] e_img;
        logic        e_busy, e_done;
        logic [1:0]  e_idx;

        //            wr    data    hold  st    sp    clr   rdy   busy  img
        vt[0]  = '{1'b0, 36'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};
        vt[1]  = '{1'b1, FA,    8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};
        vt[2]  = '{1'b1, FB,    8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};
        vt[3]  = '{1'b1, FC,    8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};
        vt[4]  = '{1'b1, FD,    8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0};
        vt[5]  = '{1'b1, FE,    8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0};
        vt[6]  = '{1'b0, 36'h0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 36'h0};
        vt[7]  = '{1'b0, 36'h0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 36'h0};
        vt[8]  = '{1'b0, 36'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};
        vt[9]  = '{1'b1, FA,    8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 36'h0};
        vt[10] = '{1'b0, 36'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};
        vt[11] = '{1'b1, FA,    8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};
        vt[12] = '{1'b0, 36'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FA};
        vt[13] = '{1'b0, 36'h0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FA};
        vt[14] = '{1'b0, 36'h0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, FA};
        vt[15] = '{1'b0, 36'h0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 36'h0};
        vt[16] = '{1'b0, 36'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};

        idle_inputs();
        bus.loop_en = 1'b0;

        // reset values while rst_n is held low
        step();
        step();
        chk_out("rst", 36'h0, 1'b0, 1'b0, 2'd0);
        chk("rst_ready", 64'(bus.wr_ready), 64'(1'b1));
        rst_n = 1'b1;
        step();

        // table: writes, full store, start/stop/clear interactions
        for (int i = 0; i < NV; i++) begin
            bus.wr_valid = vt[i].wr;
            bus.wr_data  = vt[i].data;
            bus.wr_hold  = vt[i].hold;
            bus.start    = vt[i].start;
            bus.stop     = vt[i].stop;
            bus.clear    = vt[i].clear;
            step();
            idle_inputs();
            chk($sformatf("vec%0d_ready", i), 64'(bus.wr_ready), 64'(vt[i].e_ready));
            chk($sformatf("vec%0d_busy", i),  64'(bus.busy),     64'(vt[i].e_busy));
            chk($sformatf("vec%0d_img", i),   64'(bus.img),      64'(vt[i].e_img));
            chk($sformatf("vec%0d_done", i),  64'(bus.done),     64'(1'b0));
        end

        // basic two-frame playback: A hold 1, B hold 3
        write_frame(FA, 8'd1);
        write_frame(FB, 8'd3);
        pulse_start();
        chk_out("basic_entry", FA, 1'b1, 1'b0, 2'd0);
        repeat (DIV - 1) step();
        chk_out("basic_a_end", FA, 1'b1, 1'b0, 2'd0);
        step();
        chk_out("basic_b", FB, 1'b1, 1'b0, 2'd1);
        repeat (3 * DIV - 1) step();
        chk_out("basic_b_end", FB, 1'b1, 1'b0, 2'd1);
        step();
        chk_out("basic_done", FB, 1'b0, 1'b1, 2'd1);
        step();
        chk_out("basic_after", FB, 1'b0, 1'b0, 2'd1);

        // looping playback, then drop loop_en during B
        pulse_clear();
        chk_out("loop_clr", 36'h0, 1'b0, 1'b0, 2'd1);
        write_frame(FA, 8'd1);
        write_frame(FB, 8'd1);
        bus.loop_en = 1'b1;
        pulse_start();
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("loop_w%0d_img", w), 64'(bus.img), 64'((w % 2 == 1) ? FB : FA));
            for (int c = 0; c < DIV; c++) begin
                step();
                chk($sformatf("loop_w%0d_c%0d_done", w, c), 64'(bus.done), 64'(1'b0));
            end
        end
        chk_out("loop_wrap", FA, 1'b1, 1'b0, 2'd0);
        repeat (DIV) step();
        chk_out("loop_b", FB, 1'b1, 1'b0, 2'd1);
        repeat (3) step();
        bus.loop_en = 1'b0;
        repeat (DIV - 4) step();
        chk_out("loop_b_end", FB, 1'b1, 1'b0, 2'd1);
        step();
        chk_out("loop_done", FB, 1'b0, 1'b1, 2'd1);

        // stop five cycles into frame B
        pulse_clear();
        write_frame(FA, 8'd1);
        write_frame(FB, 8'd3);
        pulse_start();
        repeat (DIV) step();
        chk_out("stop_b", FB, 1'b1, 1'b0, 2'd1);
        repeat (5) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk_out("stop_now", FB, 1'b0, 1'b0, 2'd1);
        for (int c = 0; c < 3 * DIV; c++) begin
            step();
            chk($sformatf("stop_c%0d_done", c), 64'(bus.done), 64'(1'b0));
        end
        chk_out("stop_after", FB, 1'b0, 1'b0, 2'd1);

        // asynchronous reset mid-PLAY
        pulse_clear();
        write_frame(FA, 8'd1);
        write_frame(FB, 8'd3);
        pulse_start();
        repeat (DIV + 3) step();
        chk_out("arst_pre", FB, 1'b1, 1'b0, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 36'h0, 1'b0, 1'b0, 2'd0);
        chk("arst_ready", 64'(bus.wr_ready), 64'(1'b1));
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        chk_out("arst_start", 36'h0, 1'b0, 1'b0, 2'd0);
        write_frame(FC, 8'd2);
        pulse_start();
        chk_out("arst_replay", FC, 1'b1, 1'b0, 2'd0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;

        // randomized trials against the timeline model
        for (int trial = 0; trial < 24; trial++) begin
            pulse_clear();
            n = int'($urandom_range(DEPTH, 1));
            r_n = n;
            tsum = 0;
            for (int f = 0; f < n; f++) begin
                rnd = {$urandom(), $urandom()};
                r_data[f] = rnd[35:0];
                hv = int'($urandom_range(3, 0));
                r_hold[f] = (hv == 0) ? 1 : hv;
                tsum += r_hold[f];
                write_frame(r_data[f], 8'(hv));
                repeat ($urandom_range(2, 0)) step();
            end
            big_t = tsum * DIV;
            loop = ($urandom_range(2, 0) == 2);
            if (loop) stop_at = int'($urandom_range(2 * big_t, 1));
            else if ($urandom_range(2, 0) == 0) stop_at = int'($urandom_range(big_t, 1));
            else stop_at = 0;
            horizon = loop ? stop_at + 2 : big_t + 2;
            bus.loop_en = loop;
            pulse_start();
            for (int k = 0; k <= horizon; k++) begin
                if (k > 0) begin
                    bus.stop = (k == stop_at);
                    step();
                    bus.stop = 1'b0;
                end
                stopped = (stop_at > 0) && (k >= stop_at);
                ks = stopped ? stop_at - 1 : k;
                if (!loop && ks >= big_t) begin
                    e_img  = r_data[n - 1];
                    e_idx  = 2'(n - 1);
                    e_busy = 1'b0;
                    e_done = (k == big_t) && !stopped;
                end else begin
                    fr     = frame_at(ks, loop);
                    e_img  = r_data[fr];
                    e_idx  = 2'(fr);
                    e_busy = !stopped;
                    e_done = 1'b0;
                end
                chk_out($sformatf("rnd%0d_k%0d", trial, k), e_img, e_busy, e_done, e_idx);
            end
            bus.loop_en = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_frame_scheduler.md
LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

Interface
REQ-001 Parameters (name, default, meaning):
- CLK_HZ, 12_000_000, input clock frequency.
- TICK_HZ, 1000, hold-time tick rate.
- DEPTH, 4, frame store entries; power of two, minimum 2.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- wr_valid, in, 1, frame write request.
- wr_ready, out, 1, frame write accepted this cycle when high with wr_valid.
- wr_data, in, 36, frame pixels; bit 6*r+c is row r, column c.
- wr_hold, in, 8, frame display time in ticks.
- start, in, 1, begin playback (pulse).
- stop, in, 1, abort playback (pulse).
- clear, in, 1, empty the frame store and blank the display.
- loop_en, in, 1, restart from frame 0 after the last frame.
- busy, out, 1, high while in PLAY.
- frame_idx, out, log2(DEPTH), index of the frame currently shown.
- done, out, 1, one-cycle pulse when a non-looping sequence completes.
- img, out, 36, registered frame driven to the LED matrix driver's img input.

Function
REQ-003 The block SHALL have two states, IDLE and PLAY, plus a frame store of DEPTH entries (36-bit data, 8-bit hold) and a count register (0..DEPTH).
REQ-004 wr_ready SHALL be asserted when state==IDLE and count<DEPTH.
REQ-005 When wr_valid && wr_ready, the write SHALL store {wr_data, wr_hold} at entry count and increment count.
REQ-006 When clear is asserted in IDLE, count and img SHALL go to 0 on the next edge. clear SHALL take priority over a same-cycle write. clear SHALL be ignored in PLAY.
REQ-007 IDLE->PLAY SHALL occur when start is asserted, count>0 and stop is low. start with count==0 SHALL be ignored. start in PLAY SHALL be ignored.
REQ-008 On the IDLE->PLAY edge, the block SHALL:
- set frame_idx=0;
- set img=entry[0].data;
- load the hold counter with max(entry[0].hold, 1);
- reset the tick prescaler.
REQ-009 The prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and assert an internal tick for one cycle on its terminal count. Period: exactly CLK_HZ/TICK_HZ cycles, with the first tick that many cycles after entry.
REQ-010 In PLAY, each tick SHALL decrement the hold counter. The tick on which the counter equals 1 is expiry.
REQ-011 At expiry with frame_idx<count-1, the block SHALL advance frame_idx, load img and the hold counter from the next entry (hold 0 treated as 1), and do so on the same edge.
REQ-012 At expiry with frame_idx==count-1:
- loop_en=1: wrap to entry 0 as in REQ-011.
- loop_en=0: pulse done for one cycle, go to IDLE, hold img at the last frame, keep frame_idx.
REQ-013 stop asserted in PLAY SHALL return the block to IDLE on the next edge without a done pulse, retaining img and frame_idx. stop SHALL win over a same-cycle expiry or start.
REQ-014 busy SHALL equal (state==PLAY), registered.
REQ-015 loop_en SHALL be sampled only at expiry of the last frame.
REQ-016 Writes SHALL not be possible in PLAY, so the stored frames stay stable during playback.

Reset
REQ-017 While rst_n is low, asynchronously: state=IDLE, count=0, img=0, frame_idx=0, done=0, busy=0, prescaler=0, hold counter=0. wr_ready=1 after reset.
REQ-018 Reset asserted mid-PLAY SHALL abort immediately to the reset values. Frame store contents MAY be retained but SHALL be unreachable, since count=0.

Verification (CLK_HZ=1000, TICK_HZ=100, so one tick every 10 cycles; DEPTH=4)
REQ-019 Write A=36'h000000021 with hold 1 and B=36'h00000C000 with hold 3, then pulse start:
- img=A and busy=1 one cycle after start;
- img=B 10 cycles later;
- done pulses 30 cycles after that;
- busy=0 and img stays B.
REQ-020 Write 4 frames, then assert wr_valid again: wr_ready=0 and count stays 4. Pulse clear: img=0, count=0, wr_ready=1.
REQ-021 With loop_en=1 and 2 frames of hold 1: img alternates A,B,A,B every 10 cycles and done never pulses. Drop loop_en during frame B: done pulses at B's expiry.
REQ-022 start with count=0: busy stays 0. start and stop asserted in the same cycle: busy stays 0.
REQ-023 Pulse stop 5 cycles into frame B: busy=0 next cycle, no done pulse, img=B, frame_idx=1.
REQ-024 Assert rst_n low mid-PLAY, asynchronously between clock edges: img=0, busy=0, wr_ready=1 immediately. A start after release is ignored until a new frame is written.
